multi_cycle_cpu_sequencer: RTL and testbench

//  Multi-cycle successor to the single-cycle CPU top. Owns PC, instruction register and a step FSM (FETCH/DECODE/EXEC/MEM/WB).

---
 rtl/multi_cycle_cpu_sequencer_pkg.sv | 25 ++
 rtl/multi_cycle_cpu_sequencer_bus_wait_timer.sv | 45 ++++
 rtl/multi_cycle_cpu_sequencer.sv | 129 ++++++++++++
 tb/tb_multi_cycle_cpu_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_cpu_sequencer_pkg.sv
`default_nettype none
// ==================================================================
// multi_cycle_cpu_sequencer_pkg
// Step-FSM state encoding and default widths for the sequencer.
// Rev 1.0
// ==================================================================
package multi_cycle_cpu_sequencer_pkg;

    localparam int c_STATE_W     = 3;
    localparam int c_DEF_ADDR_W  = 14;
    localparam int c_DEF_TIMEOUT = 255;
    localparam int c_WAIT_W      = 16;

    typedef enum logic [c_STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_PAUSE  = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_cpu_sequencer_bus_wait_timer.sv
`default_nettype none
// ==================================================================
// multi_cycle_cpu_sequencer_bus_wait_timer
// Counts handshake wait cycles; expired_o flags the last allowed one.
// Rev 1.0
// ==================================================================
module multi_cycle_cpu_sequencer_bus_wait_timer
    import multi_cycle_cpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam logic [c_WAIT_W-1:0] c_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] cnt_q;
    logic [c_WAIT_W-1:0] cnt_d;

    // Expiry means this waiting cycle is the TIMEOUT-th one without ack.
    assign expired_o = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_cpu_sequencer.sv
`default_nettype none
// ==================================================================
// multi_cycle_cpu_sequencer
// PC, IR and FETCH/DECODE/EXEC/MEM/WB step FSM with wait-state handshakes.
// Rev 1.0
// ==================================================================
module multi_cycle_cpu_sequencer
    import multi_cycle_cpu_sequencer_pkg::*;
#(
    parameter int               ADDR_W   = c_DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = c_DEF_TIMEOUT
) (
    input  logic              iCpuClock,
    input  logic              iCpuReset,
    output logic [ADDR_W-1:0] oProgromFetchAddr,
    output logic              oInstrReq,
    input  logic              iInstrAck,
    input  logic [31:0]       iInstruction,
    output logic [31:0]       oInstruction,
    input  logic              iIsJr,
    input  logic              iIsJ,
    input  logic              iIsJal,
    input  logic              iBranchTaken,
    input  logic [31:0]       iJrTarget,
    input  logic [ADDR_W-1:0] iBranchTarget,
    input  logic              iIsMemAccess,
    input  logic              iIsMemWrite,
    input  logic              iDoWriteReg,
    output logic              oDataReq,
    output logic              oDataWe,
    input  logic              iDataAck,
    output logic              oRegWriteEn,
    output logic [31:0]       oLinkAddress,
    input  logic              iSingleStep,
    input  logic              iStep,
    output logic              oBusError,
    output logic [31:0]       oRetired,
    output logic [2:0]        oState
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q;
    logic [31:0]       retired_q;
    logic              bus_err_q;
    logic              data_we_q;
    logic              step_prev_q;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_wait_en;
    logic              w_wait_clr;
    logic              w_expired;
    logic              w_unused;

    assign w_pc_inc   = pc_q + 1'b1;
    assign w_wait_en  = ((state_q == ST_FETCH) && !iInstrAck) ||
                        ((state_q == ST_MEM)   && !iDataAck);
    assign w_wait_clr = (state_q != ST_FETCH) && (state_q != ST_MEM);
    assign w_unused   = ^{iJrTarget[31:ADDR_W+2], iJrTarget[1:0]};

    multi_cycle_cpu_sequencer_bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_wait_timer (
        .clk_i     (iCpuClock),
        .rst_n_i   (iCpuReset),
        .clear_i   (w_wait_clr),
        .cnt_en_i  (w_wait_en),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_FETCH:  if (iInstrAck) state_d = ST_DECODE;
                       else if (w_expired) state_d = ST_ERROR;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = iIsMemAccess ? ST_MEM : ST_WB;
            ST_MEM:    if (iDataAck) state_d = ST_WB;
                       else if (w_expired) state_d = ST_ERROR;
            ST_WB: begin
                if (iIsJr)                pc_d = iJrTarget[ADDR_W+1:2];
                else if (iIsJ || iIsJal)  pc_d = ir_q[ADDR_W-1:0];
                else if (iBranchTaken)    pc_d = iBranchTarget;
                else                      pc_d = w_pc_inc;
                state_d = iSingleStep ? ST_PAUSE : ST_FETCH;
            end
            // Leaving single-step mode must not need a step pulse.
            ST_PAUSE:  if (!iSingleStep || (iStep && !step_prev_q)) state_d = ST_FETCH;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            retired_q   <= '0;
            bus_err_q   <= 1'b0;
            data_we_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            step_prev_q <= iStep;
            if ((state_q == ST_FETCH) && iInstrAck) ir_q <= iInstruction;
            if (state_q == ST_EXEC) data_we_q <= iIsMemWrite;
            if (state_q == ST_WB) retired_q <= retired_q + 1'b1;
            if (state_d == ST_ERROR) bus_err_q <= 1'b1;
        end
    end

    // Strobes are qualified by the reset pin so they drop the instant reset asserts.
    assign oInstrReq         = iCpuReset && (state_q == ST_FETCH);
    assign oDataReq          = iCpuReset && (state_q == ST_MEM);
    assign oDataWe           = oDataReq && data_we_q;
    assign oRegWriteEn       = iCpuReset && (state_q == ST_WB) && (iDoWriteReg || iIsJal);
    assign oLinkAddress      = 32'({w_pc_inc, 2'b00});
    assign oProgromFetchAddr = pc_q;
    assign oInstruction      = ir_q;
    assign oBusError         = bus_err_q;
    assign oRetired          = retired_q;
    assign oState            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_cpu_sequencer.sv
`default_nettype none
// Bench for multi_cycle_cpu_sequencer: table of instructions with a
// scoreboard queue, plus hand sequences for single-step, reset and timeout.
`timescale 1ns/1ps
module tb_multi_cycle_cpu_sequencer;
    import multi_cycle_cpu_sequencer_pkg::*;

    localparam int AW  = 14;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic          instr_req;
    logic          instr_ack = 1'b0;
    logic [31:0]   instr_in = '0;
    logic [31:0]   ir;
    logic          is_jr = 0, is_j = 0, is_jal = 0, br_taken = 0;
    logic [31:0]   jr_tgt = '0;
    logic [AW-1:0] br_tgt = '0;
    logic          is_mem = 0, is_mw = 0, do_wr = 0;
    logic          data_req, data_we;
    logic          data_ack = 1'b0;
    logic          rwe;
    logic [31:0]   link;
    logic          sstep = 0, step = 0;
    logic          bus_err;
    logic [31:0]   retired;
    logic [2:0]    st;

    always #5 clk = ~clk;

    multi_cycle_cpu_sequencer #(.ADDR_W(AW), .RESET_PC('0), .TIMEOUT(TMO)) dut (
        .iCpuClock(clk), .iCpuReset(rst_n), .oProgromFetchAddr(pc),
        .oInstrReq(instr_req), .iInstrAck(instr_ack), .iInstruction(instr_in),
        .oInstruction(ir), .iIsJr(is_jr), .iIsJ(is_j), .iIsJal(is_jal),
        .iBranchTaken(br_taken), .iJrTarget(jr_tgt), .iBranchTarget(br_tgt),
        .iIsMemAccess(is_mem), .iIsMemWrite(is_mw), .iDoWriteReg(do_wr),
        .oDataReq(data_req), .oDataWe(data_we), .iDataAck(data_ack),
        .oRegWriteEn(rwe), .oLinkAddress(link), .iSingleStep(sstep),
        .iStep(step), .oBusError(bus_err), .oRetired(retired), .oState(st)
    );

    typedef struct {
        string         name;
        logic [31:0]   instr;
        int            fw, dw;
        logic          mem, we, jr, j, jal, br, dowr;
        logic [31:0]   jrt;
        logic [AW-1:0] brt;
        logic [AW-1:0] exp_pc;
        int            exp_cyc;
        logic          exp_rwe;
        logic [31:0]   exp_link;
    } vec_t;

    typedef struct {
        string         name;
        logic [AW-1:0] pc;
        logic [31:0]   ret;
        int            cyc;
        logic          rwe;
        logic [31:0]   instr;
        int            dreq;
        logic          we;
        logic [31:0]   link;
        logic          jal;
        logic          mem;
        logic [2:0]    st;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] exp_ret = '0;
    int          last_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] ins, input int fw, input int dw,
                                input logic mem, input logic we, input logic jr, input logic j,
                                input logic jal, input logic br, input logic dowr,
                                input logic [31:0] jrt, input logic [AW-1:0] brt,
                                input logic [AW-1:0] epc, input int ecyc, input logic erwe,
                                input logic [31:0] elink);
        vec_t v;
        v.name = nm; v.instr = ins; v.fw = fw; v.dw = dw; v.mem = mem; v.we = we;
        v.jr = jr; v.j = j; v.jal = jal; v.br = br; v.dowr = dowr; v.jrt = jrt; v.brt = brt;
        v.exp_pc = epc; v.exp_cyc = ecyc; v.exp_rwe = erwe; v.exp_link = elink;
        return v;
    endfunction

    task automatic release_reset();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          cyc, fc, dc, dreq, rwe_cnt;
        logic        wb_seen, we_seen;
        logic [31:0] link_s, ir_s;
        exp_ret++;
        e.name = v.name; e.pc = v.exp_pc; e.ret = exp_ret; e.cyc = v.exp_cyc; e.rwe = v.exp_rwe;
        e.instr = v.instr; e.dreq = v.dw + 1; e.we = v.we; e.link = v.exp_link; e.jal = v.jal;
        e.mem = v.mem; e.st = sstep ? 3'd5 : 3'd0;
        sb.push_back(e);
        is_mem = v.mem; is_mw = v.we; is_jr = v.jr; is_j = v.j; is_jal = v.jal;
        br_taken = v.br; do_wr = v.dowr; jr_tgt = v.jrt; br_tgt = v.brt;
        cyc = 0; fc = 0; dc = 0; dreq = 0; rwe_cnt = 0; wb_seen = 0; we_seen = 0;
        link_s = '0; ir_s = '0;
        while (!wb_seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            instr_ack = 0; data_ack = 0;
            rwe_cnt += int'(rwe);
            case (st)
                3'd0: begin
                    // Stray data acks while fetching must be ignored.
                    if (fc == v.fw) begin instr_ack = 1; instr_in = v.instr; end
                    else begin data_ack = 1; instr_in = 32'hDEAD_BEEF; end
                    fc++;
                end
                3'd3: begin
                    dreq += int'(data_req);
                    we_seen = data_we;
                    if (dc == v.dw) data_ack = 1; else instr_ack = 1;
                    dc++;
                end
                3'd4: begin wb_seen = 1; link_s = link; ir_s = ir; end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        instr_ack = 0; data_ack = 0;
        e = sb.pop_front();
        last_cyc = cyc;
        chk({e.name, " wb_reached"}, 32'(wb_seen), 32'd1);
        chk({e.name, " next_pc"},    32'(pc), 32'(e.pc));
        chk({e.name, " retired"},    retired, e.ret);
        chk({e.name, " cycles"},     32'(cyc), 32'(e.cyc));
        chk({e.name, " regwe"},      32'(rwe_cnt), 32'(e.rwe));
        chk({e.name, " ir"},         ir_s, e.instr);
        chk({e.name, " state"},      32'(st), 32'(e.st));
        if (e.mem) begin
            chk({e.name, " dreq_cycles"}, 32'(dreq), 32'(e.dreq));
            chk({e.name, " data_we"},     32'(we_seen), 32'(e.we));
        end
        if (e.jal) chk({e.name, " link"}, link_s, e.link);
    endtask

    vec_t vt[12];
    int   cnt;
    int   sum;

    initial begin
        vt[0]  = mk("addu0", 32'h0022_1821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd1, 4, 1, '0);
        vt[1]  = mk("addu1", 32'h0043_2021, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd2, 4, 1, '0);
        vt[2]  = mk("addu2", 32'h0064_2821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd3, 4, 1, '0);
        vt[3]  = mk("lw",    32'h8C22_0004, 0, 4, 1,0,0,0,0,0,1, '0, '0, 14'd4, 9, 1, '0);
        vt[4]  = mk("sw",    32'hAC22_0008, 2, 0, 1,1,0,0,0,0,0, '0, '0, 14'd5, 7, 0, '0);
        vt[5]  = mk("jal",   32'h0C00_0040, 0, 0, 0,0,0,0,1,1,0, '0, 14'h100, 14'h40, 4, 1, 32'h18);
        vt[6]  = mk("jr_beq",32'h0020_0008, 0, 0, 0,0,1,0,0,1,0, 32'h200, 14'h10, 14'h80, 4, 0, '0);
        vt[7]  = mk("beq",   32'h1022_0010, 0, 0, 0,0,0,0,0,1,0, '0, 14'h3FFF, 14'h3FFF, 4, 0, '0);
        vt[8]  = mk("wrap",  32'h0022_1821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'h0, 4, 1, '0);
        vt[9]  = mk("j_beq", 32'h0800_0123, 0, 0, 0,0,0,1,0,1,0, '0, 14'h7, 14'h123, 4, 0, '0);
        vt[10] = mk("jr_hi", 32'h0020_0008, 0, 0, 0,0,1,0,0,0,0, 32'hFFFF_0010, '0, 14'h4, 4, 0, '0);
        vt[11] = mk("lw_w1", 32'h8C22_000C, 1, 1, 1,0,0,0,0,0,1, '0, '0, 14'd5, 7, 1, '0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst state",   32'(st), 32'd0);
        chk("rst pc",      32'(pc), 32'd0);
        chk("rst ir",      ir, 32'd0);
        chk("rst retired", retired, 32'd0);
        chk("rst buserr",  32'(bus_err), 32'd0);
        chk("rst ireq",    32'(instr_req), 32'd0);
        release_reset();

        sum = 0;
        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i]);
            if (i < 3) sum += last_cyc;
            if (i == 2) chk("alu3 total cycles", 32'(sum), 32'd12);
        end

        // Single-step: PAUSE after each WB, a step edge releases exactly one.
        sstep = 1;
        run_vec(mk("ss0", 32'h0022_1821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd6, 4, 1, '0));
        repeat (3) @(negedge clk);
        chk("pause hold state", 32'(st), 32'd5);
        chk("pause no ireq",    32'(instr_req), 32'd0);
        chk("pause pc",         32'(pc), 32'd6);
        step = 1;
        @(posedge clk); #1;
        chk("step release", 32'(st), 32'd0);
        run_vec(mk("ss1", 32'h0022_1821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd7, 4, 1, '0));
        repeat (2) @(negedge clk);
        chk("step level no advance", 32'(st), 32'd5);
        step = 0;
        @(negedge clk);
        sstep = 0;
        @(posedge clk); #1;
        chk("sstep drop exit", 32'(st), 32'd0);

        // Reset mid-MEM
        is_mem = 1; is_mw = 0; do_wr = 1; is_jr = 0; is_j = 0; is_jal = 0; br_taken = 0;
        cnt = 0;
        while (st != 3'd3 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            instr_ack = (st == 3'd0);
        end
        instr_ack = 0;
        chk("mid-mem reached", 32'(st), 32'd3);
        chk("mid-mem dreq", 32'(data_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst dreq drop", 32'(data_req), 32'd0);
        chk("rst mem state", 32'(st), 32'd0);
        chk("rst mem pc",    32'(pc), 32'd0);
        chk("rst mem ret",   retired, 32'd0);
        exp_ret = '0;
        is_mem = 0; do_wr = 0;
        release_reset();

        // Timeout: no instruction ack ever arrives.
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (st == 3'd6) break;
            if (st == 3'd0 && instr_req) cnt++;
        end
        chk("timeout fetch cycles", 32'(cnt), 32'(TMO));
        chk("timeout state",  32'(st), 32'd6);
        chk("timeout buserr", 32'(bus_err), 32'd1);
        instr_ack = 1; data_ack = 1;
        repeat (3) @(negedge clk);
        chk("error no ireq",  32'(instr_req), 32'd0);
        chk("error no dreq",  32'(data_req), 32'd0);
        chk("error terminal", 32'(st), 32'd6);
        instr_ack = 0; data_ack = 0;
        rst_n = 1'b0;
        #1;
        chk("err rst buserr", 32'(bus_err), 32'd0);
        chk("err rst pc",     32'(pc), 32'd0);
        release_reset();
        run_vec(mk("post_err", 32'h0022_1821, 0, 0, 0,0,0,0,0,0,1, '0, '0, 14'd1, 4, 1, '0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
